align_sequencer: RTL and testbench

ALIGN_SEQUENCER -- requirements
Module: align_sequencer

---
 rtl/align_sequencer.sv | 139 +++++++++++++
 tb/tb_align_sequencer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/align_sequencer.sv
// align_sequencer -- exponent-alignment sequencer for a floating-point adder.
//
// Takes an operand pair (biased exponent + hidden-bit mantissa each), picks
// the larger operand, and drives the smaller mantissa to an external
// combinational right barrel shifter. The shifter result is registered one
// cycle later and presented with the larger operand on a valid/ready output.
//
// Ports
//   Clk, Rst_n            clock, asynchronous active-low reset
//   InValid / InReady     operand-pair handshake (InReady high only in IDLE)
//   ExpA, ExpB            8-bit biased exponents
//   MantA, MantB          24-bit hidden bit + fraction
//   ShMantissa, ShShifts  operand and shift count driven to the shifter
//   ShAligned             shifter result (combinational from ShMantissa/ShShifts)
//   OutValid / OutReady   result handshake
//   OutExp, OutBig        larger exponent, larger mantissa as {mant,1'b0}
//   OutAligned            smaller mantissa after alignment
//   OutSwap               B was the larger operand
//   OutZeroed             difference exceeded MaxShift; small operand flushed
module align_sequencer #(
   parameter int DataSize = 25,
   parameter int MaxShift = 24
) (
   input  logic                Clk,
   input  logic                Rst_n,
   input  logic                InValid,
   output logic                InReady,
   input  logic [7:0]          ExpA,
   input  logic [7:0]          ExpB,
   input  logic [23:0]         MantA,
   input  logic [23:0]         MantB,
   output logic [DataSize-1:0] ShMantissa,
   output logic [4:0]          ShShifts,
   input  logic [DataSize-1:0] ShAligned,
   output logic                OutValid,
   input  logic                OutReady,
   output logic [7:0]          OutExp,
   output logic [DataSize-1:0] OutBig,
   output logic [DataSize-1:0] OutAligned,
   output logic                OutSwap,
   output logic                OutZeroed
);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t              state_q;
   logic                in_ready_q;
   logic                out_valid_q;
   logic [DataSize-1:0] sh_mant_q;
   logic [4:0]          sh_shifts_q;
   logic [7:0]          out_exp_q;
   logic [DataSize-1:0] out_big_q;
   logic [DataSize-1:0] out_aligned_q;
   logic                out_swap_q;
   logic                out_zeroed_q;

   // Operand ordering, evaluated on the live inputs and loaded on accept.
   logic                a_big;
   logic [7:0]          big_exp_d, small_exp_d, diff_d;
   logic [23:0]         big_mant_d, small_mant_d;
   logic                zeroed_d;
   logic [4:0]          shifts_d;

   always_comb begin
      a_big        = (ExpA > ExpB) || ((ExpA == ExpB) && (MantA >= MantB));
      big_exp_d    = a_big ? ExpA  : ExpB;
      small_exp_d  = a_big ? ExpB  : ExpA;
      big_mant_d   = a_big ? MantA : MantB;
      small_mant_d = a_big ? MantB : MantA;
      // big exponent is never below the small one, so this cannot wrap
      diff_d       = big_exp_d - small_exp_d;
      zeroed_d     = diff_d > 8'(MaxShift);
      shifts_d     = zeroed_d ? 5'd0 : diff_d[4:0];
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q       <= IDLE;
         in_ready_q    <= 1'b0;
         out_valid_q   <= 1'b0;
         sh_mant_q     <= '0;
         sh_shifts_q   <= '0;
         out_exp_q     <= '0;
         out_big_q     <= '0;
         out_aligned_q <= '0;
         out_swap_q    <= 1'b0;
         out_zeroed_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               // in_ready_q is low only on the first cycle after reset release
               in_ready_q <= 1'b1;
               if (InValid && in_ready_q) begin
                  state_q      <= SHIFT;
                  in_ready_q   <= 1'b0;
                  sh_mant_q    <= DataSize'({small_mant_d, 1'b0});
                  sh_shifts_q  <= shifts_d;
                  // previous result is already consumed, so these may change now
                  out_exp_q    <= big_exp_d;
                  out_big_q    <= DataSize'({big_mant_d, 1'b0});
                  out_swap_q   <= ~a_big;
                  out_zeroed_q <= zeroed_d;
               end
            end
            SHIFT: begin
               state_q       <= DONE;
               out_valid_q   <= 1'b1;
               out_aligned_q <= out_zeroed_q ? '0 : ShAligned;
               // shifter operands are only meaningful during SHIFT
               sh_mant_q     <= '0;
               sh_shifts_q   <= '0;
            end
            DONE: begin
               if (OutReady) begin
                  state_q     <= IDLE;
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
               end
            end
            default: begin
               state_q     <= IDLE;
               in_ready_q  <= 1'b0;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign InReady    = in_ready_q;
   assign OutValid   = out_valid_q;
   assign ShMantissa = sh_mant_q;
   assign ShShifts   = sh_shifts_q;
   assign OutExp     = out_exp_q;
   assign OutBig     = out_big_q;
   assign OutAligned = out_aligned_q;
   assign OutSwap    = out_swap_q;
   assign OutZeroed  = out_zeroed_q;

endmodule

// File: tb/tb_align_sequencer.sv
module tb_align_sequencer;

   localparam int DW = 25;

   logic          Clk = 1'b0;
   logic          Rst_n;
   logic          InValid;
   logic          InReady;
   logic [7:0]    ExpA, ExpB;
   logic [23:0]   MantA, MantB;
   logic [DW-1:0] ShMantissa;
   logic [4:0]    ShShifts;
   logic [DW-1:0] ShAligned;
   logic          OutValid;
   logic          OutReady;
   logic [7:0]    OutExp;
   logic [DW-1:0] OutBig, OutAligned;
   logic          OutSwap, OutZeroed;

   align_sequencer #(.DataSize(DW), .MaxShift(24)) dut (
      .Clk(Clk), .Rst_n(Rst_n),
      .InValid(InValid), .InReady(InReady),
      .ExpA(ExpA), .ExpB(ExpB), .MantA(MantA), .MantB(MantB),
      .ShMantissa(ShMantissa), .ShShifts(ShShifts), .ShAligned(ShAligned),
      .OutValid(OutValid), .OutReady(OutReady),
      .OutExp(OutExp), .OutBig(OutBig), .OutAligned(OutAligned),
      .OutSwap(OutSwap), .OutZeroed(OutZeroed)
   );

   // external right barrel shifter
   assign ShAligned = ShMantissa >> ShShifts;

   always #5 Clk = ~Clk;

   typedef struct {
      logic [4:0]    sh;
      logic [DW-1:0] mant;
      logic [7:0]    e;
      logic [DW-1:0] big;
      logic [DW-1:0] al;
      logic          sw;
      logic          z;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_err = 0;
   time  bp_until = 0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
      end
   endtask

   task automatic fail(input string nm);
      n_cmp++;
      n_err++;
      $display("FAIL %s at %0t", nm, $time);
   endtask

   // Reference: ordering, difference and alignment from plain arithmetic.
   function automatic exp_t model(input logic [7:0] ea, input logic [7:0] eb,
                                  input logic [23:0] ma, input logic [23:0] mb);
      exp_t r;
      int d;
      logic sw;
      logic [23:0] bm, sm;
      sw   = !((ea > eb) || (ea == eb && ma >= mb));
      bm   = sw ? mb : ma;
      sm   = sw ? ma : mb;
      d    = sw ? (int'(eb) - int'(ea)) : (int'(ea) - int'(eb));
      r.e  = sw ? eb : ea;
      r.sw = sw;
      r.big  = {bm, 1'b0};
      r.mant = {sm, 1'b0};
      r.z  = d > 24;
      r.sh = r.z ? 5'd0 : 5'(d);
      r.al = r.z ? '0 : (r.mant >> d);
      return r;
   endfunction

   // Present a pair and hold it until accepted; returns just after the accept edge.
   task automatic send(input logic [7:0] ea, input logic [7:0] eb,
                       input logic [23:0] ma, input logic [23:0] mb);
      bit ok;
      ExpA = ea; ExpB = eb; MantA = ma; MantB = mb;
      InValid = 1'b1;
      ok = 0;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge Clk);
         if (InReady) begin
            q.push_back(model(ea, eb, ma, mb));
            ok = 1;
         end
      end
      if (!ok) fail("accept_timeout");
      @(posedge Clk); #1;
   endtask

   // downstream readiness: random, or forced low for directed backpressure
   initial begin
      OutReady = 1'b0;
      forever begin
         @(posedge Clk); #1;
         if ($time < bp_until) OutReady = 1'b0;
         else OutReady = ($urandom_range(0, 2) != 0);
      end
   end

   // monitor / scoreboard
   initial begin
      int acc_cyc, cyc;
      bit shift_chk, idle_chk, prev_ov;
      exp_t e;
      acc_cyc = -10; cyc = 0;
      shift_chk = 0; idle_chk = 0; prev_ov = 0;
      forever begin
         @(negedge Clk);
         cyc++;
         if (!Rst_n) begin
            q.delete();
            shift_chk = 0; idle_chk = 0; prev_ov = 0; acc_cyc = -10;
         end else begin
            if (idle_chk) begin
               check("idle_inready", InReady, 1);
               check("idle_outvalid", OutValid, 0);
               idle_chk = 0;
            end
            if (shift_chk) begin
               if (q.size() == 0) fail("shift_no_expect");
               else begin
                  e = q[0];
                  check("shshifts", ShShifts, e.sh);
                  check("shmantissa", ShMantissa, e.mant);
               end
               check("shift_inready", InReady, 0);
               check("shift_outvalid", OutValid, 0);
               shift_chk = 0;
            end
            if (OutValid) begin
               if (q.size() == 0) fail("spurious_outvalid");
               else begin
                  e = q[0];
                  if (!prev_ov) check("latency", 64'(cyc - acc_cyc), 2);
                  check("outexp", OutExp, e.e);
                  check("outbig", OutBig, e.big);
                  check("outaligned", OutAligned, e.al);
                  check("outswap", OutSwap, e.sw);
                  check("outzeroed", OutZeroed, e.z);
                  check("done_inready", InReady, 0);
                  if (OutReady) begin
                     void'(q.pop_front());
                     idle_chk = 1;
                  end
               end
            end
            if (InValid && InReady) begin
               acc_cyc = cyc;
               shift_chk = 1;
            end
            prev_ov = OutValid;
         end
      end
   end

   task automatic check_all_zero(input string tag);
      check({tag, "_inready"}, InReady, 0);
      check({tag, "_outvalid"}, OutValid, 0);
      check({tag, "_shifter"}, {ShShifts, ShMantissa}, 0);
      check({tag, "_outexp"}, OutExp, 0);
      check({tag, "_outdata"}, {OutBig, OutAligned}, 0);
      check({tag, "_flags"}, {OutSwap, OutZeroed}, 0);
   endtask

   initial begin
      logic [7:0]  ea, eb;
      logic [23:0] ma, mb;
      int t, mode;
      bit ok;
      Rst_n = 1'b0; InValid = 1'b0;
      ExpA = '0; ExpB = '0; MantA = '0; MantB = '0;
      repeat (2) @(negedge Clk);
      check_all_zero("reset");
      #2 Rst_n = 1'b1;
      #1 check("inready_before_edge", InReady, 0);
      @(posedge Clk); #1;
      check("inready_after_release", InReady, 1);

      // directed corner pairs
      send(8'd130, 8'd128, 24'hC00000, 24'h800000);
      send(8'd100, 8'd103, 24'h800000, 24'h900000);
      send(8'd150, 8'd126, 24'hA00000, 24'h800000);   // diff 24
      send(8'd151, 8'd126, 24'hA00000, 24'h800000);   // diff 25
      send(8'd126, 8'd150, 24'h800000, 24'hFFFFFF);   // diff 24, swapped
      send(8'd127, 8'd127, 24'h800001, 24'h800002);   // equal exp
      send(8'd127, 8'd127, 24'h800002, 24'h800002);   // fully equal
      // backpressure with InValid held high throughout
      bp_until = $time + 90;
      send(8'd140, 8'd135, 24'hF0F0F0, 24'hABCDEF);

      // randomized pairs
      for (int i = 0; i < 250; i++) begin
         ea   = 8'($urandom_range(0, 255));
         mode = $urandom_range(0, 3);
         ma   = {1'b1, 23'($urandom)};
         mb   = {1'b1, 23'($urandom)};
         if (mode == 0) eb = 8'($urandom_range(0, 255));
         else if (mode == 3) begin
            eb = ea;
            if ($urandom_range(0, 1) == 1) mb = ma;
         end else begin
            t = int'(ea) + $urandom_range(0, 60) - 30;
            if (t < 0) t = 0;
            if (t > 255) t = 255;
            eb = 8'(t);
         end
         if ($urandom_range(0, 7) == 0) ma = 24'($urandom);
         send(ea, eb, ma, mb);
         if ($urandom_range(0, 3) == 0) begin
            InValid = 1'b0;
            repeat ($urandom_range(1, 4)) begin @(posedge Clk); #1; end
         end
      end
      InValid = 1'b0;

      ok = 0;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge Clk);
         if (q.size() == 0) ok = 1;
      end
      if (!ok) fail("drain_timeout");

      // reset while a pair is in SHIFT
      send(8'd90, 8'd80, 24'hC00000, 24'h812345);
      InValid = 1'b0;
      Rst_n = 1'b0;
      #1 check_all_zero("midreset");
      @(negedge Clk);
      @(posedge Clk); #3;
      Rst_n = 1'b1;
      @(posedge Clk); #1;
      check("post_reset_inready", InReady, 1);
      repeat (6) begin
         @(negedge Clk);
         check("post_reset_no_outvalid", OutValid, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

endmodule
